// File: rtl/mxint8_block_assembler_pkg.sv
// Shared constants and block type for the MXINT8 block assembler.
package mxint8_pkg;

    localparam int BLOCK_SIZE = 32;
    localparam int ELEM_W     = 8;
    localparam int SCALE_W    = 8;
    localparam int IDX_W      = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    localparam logic [SCALE_W-1:0] E8M0_NAN = 8'hFF;

    typedef logic [ELEM_W-1:0]  elem_t;
    typedef logic [SCALE_W-1:0] scale_t;

    typedef struct packed {
        scale_t                                scale_a;
        scale_t                                scale_b;
        logic [BLOCK_SIZE-1:0][ELEM_W-1:0]     elem_a;
        logic [BLOCK_SIZE-1:0][ELEM_W-1:0]     elem_b;
    } mx_block_t;

    function automatic logic is_e8m0_nan(input scale_t s);
        return (s == E8M0_NAN);
    endfunction

endpackage

// File: rtl/mxint8_block_assembler_if.sv
// Beat-input and block-output handshake bundle of the MXINT8 block assembler.
interface mxint8_block_assembler_if;
    import mxint8_pkg::*;

    logic                              in_valid;
    logic                              in_ready;
    logic                              in_first;
    scale_t                            in_scale_a;
    scale_t                            in_scale_b;
    elem_t                             in_elem_a;
    elem_t                             in_elem_b;
    logic                              out_valid;
    logic                              out_ready;
    scale_t                            out_scale_a;
    scale_t                            out_scale_b;
    logic [BLOCK_SIZE-1:0][ELEM_W-1:0] out_elem_a;
    logic [BLOCK_SIZE-1:0][ELEM_W-1:0] out_elem_b;
    logic                              out_nan;
    logic                              err_framing;

    modport master (
        output in_valid, in_first, in_scale_a, in_scale_b, in_elem_a, in_elem_b, out_ready,
        input  in_ready, out_valid, out_scale_a, out_scale_b, out_elem_a, out_elem_b,
               out_nan, err_framing
    );

    modport slave (
        input  in_valid, in_first, in_scale_a, in_scale_b, in_elem_a, in_elem_b, out_ready,
        output in_ready, out_valid, out_scale_a, out_scale_b, out_elem_a, out_elem_b,
               out_nan, err_framing
    );

endinterface

// File: rtl/mxint8_block_assembler_bank.sv
// One ping-pong bank: block storage plus its full flag.
module mxint8_block_bank
    import mxint8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_slot,
    input  logic             wr_first,
    input  scale_t           scale_a,
    input  scale_t           scale_b,
    input  elem_t            elem_a,
    input  elem_t            elem_b,
    input  logic             set_full,
    input  logic             clr_full,
    output logic             full_r,
    output mx_block_t        blk_r
);

    // Element/scale storage and full flag; set and clear never coincide on one bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_r  <= '0;
            full_r <= 1'b0;
        end else begin
            if (wr_en) begin
                blk_r.elem_a[wr_slot] <= elem_a;
                blk_r.elem_b[wr_slot] <= elem_b;
                if (wr_first) begin
                    blk_r.scale_a <= scale_a;
                    blk_r.scale_b <= scale_b;
                end
            end
            if (set_full) begin
                full_r <= 1'b1;
            end else if (clr_full) begin
                full_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mxint8_block_assembler.sv
// Collects paired int8 beats into BLOCK_SIZE blocks and presents them through a
// two-bank ping-pong buffer with strict FIFO order.
module mxint8_block_assembler
    import mxint8_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    mxint8_block_assembler_if.slave  bus
);

    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic             err_framing_r;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;
    logic             drop_s;
    logic             restart_s;
    logic             wr_en_s;
    logic [IDX_W-1:0] wr_slot_s;
    logic             last_s;
    logic             drain_s;

    logic [1:0]       full_s;
    logic [1:0]       bank_wr_s;
    logic [1:0]       bank_set_s;
    logic [1:0]       bank_clr_s;
    mx_block_t        blk_s [2];
    mx_block_t        blk_out_s;

    // Handshake decode, framing check and fill-index update.
    always_comb begin
        in_ready_s  = wr_ptr_r ? ~full_s[1] : ~full_s[0];
        out_valid_s = rd_ptr_r ? full_s[1] : full_s[0];
        accept_s    = bus.in_valid & in_ready_s;
        drop_s      = accept_s & ~bus.in_first & (idx_r == '0);
        restart_s   = accept_s & bus.in_first & (idx_r != '0);
        wr_en_s     = accept_s & ~drop_s;
        wr_slot_s   = bus.in_first ? '0 : idx_r;
        last_s      = wr_en_s & (wr_slot_s == IDX_W'(BLOCK_SIZE - 1));
        drain_s     = out_valid_s & bus.out_ready;
        if (last_s) begin
            idx_nxt_s = '0;
        end else if (wr_en_s) begin
            idx_nxt_s = wr_slot_s + IDX_W'(1);
        end else begin
            idx_nxt_s = idx_r;
        end
        bank_wr_s  = 2'b00;
        bank_set_s = 2'b00;
        bank_clr_s = 2'b00;
        bank_wr_s[wr_ptr_r]  = wr_en_s;
        bank_set_s[wr_ptr_r] = last_s;
        bank_clr_s[rd_ptr_r] = drain_s;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        mxint8_block_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (bank_wr_s[g]),
            .wr_slot  (wr_slot_s),
            .wr_first (bus.in_first),
            .scale_a  (bus.in_scale_a),
            .scale_b  (bus.in_scale_b),
            .elem_a   (bus.in_elem_a),
            .elem_b   (bus.in_elem_b),
            .set_full (bank_set_s[g]),
            .clr_full (bank_clr_s[g]),
            .full_r   (full_s[g]),
            .blk_r    (blk_s[g])
        );
    end

    // Fill index, bank pointers and the framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r         <= '0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            err_framing_r <= 1'b0;
        end else begin
            idx_r         <= idx_nxt_s;
            err_framing_r <= drop_s | restart_s;
            if (last_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (drain_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Output mux selects the oldest full bank.
    always_comb begin
        if (rd_ptr_r) begin
            blk_out_s = blk_s[1];
        end else begin
            blk_out_s = blk_s[0];
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_scale_a = blk_out_s.scale_a;
    assign bus.out_scale_b = blk_out_s.scale_b;
    assign bus.out_elem_a  = blk_out_s.elem_a;
    assign bus.out_elem_b  = blk_out_s.elem_b;
    assign bus.out_nan     = is_e8m0_nan(blk_out_s.scale_a) | is_e8m0_nan(blk_out_s.scale_b);
    assign bus.err_framing = err_framing_r;

endmodule
